// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTL by a run-time amount, at most STEP
// bit positions per clock, under a start/busy/done handshake.
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] M_SLL  = 2'b00;
  localparam logic [1:0] M_SRL  = 2'b01;
  localparam logic [1:0] M_SRA  = 2'b10;
  localparam logic [1:0] M_ROTL = 2'b11;

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] ONE_K  = SHAMT_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     work;
  logic [1:0]           mode_q;
  logic [SHAMT_W-1:0]   remaining;
  logic [SHAMT_W-1:0]   step_k;
  logic [WIDTH-1:0]     work_nxt;
  logic                 last_step;

  // One partial shift by k positions, 1 <= k <= STEP. The rotate complement
  // WIDTH-k is taken modulo 2**SHAMT_W, which equals WIDTH.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0]   w,
    input logic [1:0]         m,
    input logic [SHAMT_W-1:0] k
  );
    logic signed [WIDTH-1:0] ws;
    logic [SHAMT_W-1:0]      rk;
    logic [WIDTH-1:0]        r;
    ws = w;
    rk = ~k + ONE_K;
    case (m)
      M_SLL:   r = w << k;
      M_SRL:   r = w >> k;
      M_SRA:   r = ws >>> k;
      M_ROTL:  r = (w << k) | (w >> rk);
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    step_k    = (remaining < STEP_K) ? remaining : STEP_K;
    last_step = (remaining == step_k);
    work_nxt  = shift_step(work, mode_q, step_k);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: operand capture, iterative shift, result capture on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      mode_q    <= '0;
      remaining <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work      <= data_in;
            mode_q    <= mode;
            remaining <= shamt;
            if (shamt == '0) begin
              result <= data_in;
            end
          end
        end
        S_SHIFT: begin
          work      <= work_nxt;
          remaining <= remaining - step_k;
          if (last_step) begin
            result <= work_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: scoreboarded STEP=1 instance plus a STEP=4 instance.
module tb_iter_shift_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          start4;
  logic [1:0]    mode;
  logic [W-1:0]  data_in;
  logic [4:0]    shamt;
  logic          busy, done, busy4, done4;
  logic [W-1:0]  result, result4;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int busy_run = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    int           done_cyc;
    int           busy_len;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  iter_shift_unit #(.WIDTH(W), .SHAMT_W(5), .STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
    .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  iter_shift_unit #(.WIDTH(W), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] d,
                                             input logic [4:0] s);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: r = (s == 5'd0) ? d : ((d << s) | (d >> (W - int'(s))));
    endcase
    return r;
  endfunction

  // Monitor: pop an expectation on every done pulse of the STEP=1 instance
  always @(negedge clk) begin
    if (busy) busy_run++;
    else      busy_run = 0;
    if (done && prev_done) check("done_one_cycle", 32'd1, 32'd0);
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_len", busy_run, e.busy_len);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [1:0] m, input logic [W-1:0] d, input logic [4:0] s);
    exp_t x;
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    data_in = d;
    shamt   = s;
    x.res      = ref_shift(m, d, s);
    x.done_cyc = cyc + 1 + int'(s);
    x.busy_len = int'(s) + 1;
    sb_q.push_back(x);
    @(negedge clk);
    start   = 1'b0;
    mode    = 2'($urandom);
    data_in = $urandom;
    shamt   = 5'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic op4(input logic [1:0] m, input logic [W-1:0] d, input logic [4:0] s);
    int c0;
    int lat;
    bit seen;
    @(negedge clk);
    start4  = 1'b1;
    mode    = m;
    data_in = d;
    shamt   = s;
    c0      = cyc;
    lat     = (int'(s) + 3) / 4;
    @(negedge clk);
    start4  = 1'b0;
    data_in = $urandom;
    seen    = 1'b0;
    if (done4) seen = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("s4_done_seen", 32'(seen), 32'd1);
    check("s4_done_cycle", cyc, c0 + 1 + lat);
    check("s4_result", result4, ref_shift(m, d, s));
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    start4  = 1'b0;
    mode    = 2'b00;
    data_in = '0;
    shamt   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_result4", result4, 0);
    rst = 1'b0;

    issue(2'b00, 32'h0000_0001, 5'd31);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_result", result, 32'h8000_0000);

    issue(2'b10, 32'h8000_0000, 5'd4);
    wait_done();
    check("sra_lit", result, 32'hF800_0000);
    issue(2'b01, 32'h8000_0000, 5'd4);
    wait_done();
    check("srl_lit", result, 32'h0800_0000);
    issue(2'b11, 32'h8000_0001, 5'd1);
    wait_done();
    check("rotl_lit", result, 32'h0000_0003);
    issue(2'b00, 32'hFFFF_FFFF, 5'd2);
    wait_done();
    check("branch_lit", result, 32'hFFFF_FFFC);
    issue(2'b00, 32'h1234_5678, 5'd0);
    wait_done();

    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom), $urandom, 5'($urandom));
      wait_done();
    end

    // start re-asserted with different operands through SHIFT and DONE
    issue(2'b00, 32'h0000_00F0, 5'd8);
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b11;
    data_in = 32'hDEAD_BEEF;
    shamt   = 5'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        @(negedge clk);
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_busy", busy, 0);
    check("ignored_result", result, 32'h0000_F000);
    check("ignored_sb", sb_q.size(), 0);

    // reset in the middle of SHIFT discards the operation
    issue(2'b01, 32'hCAFE_F00D, 5'd20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    repeat (30) @(negedge clk);
    check("midrst_idle", busy, 0);

    issue(2'b11, 32'hA5A5_0000, 5'd16);
    wait_done();
    check("fresh_lit", result, 32'h0000_A5A5);

    op4(2'b00, 32'h0000_0003, 5'd5);
    check("s4_lit", result4, 32'h0000_0060);
    op4(2'b10, 32'h8000_0000, 5'd7);
    op4(2'b11, 32'h8000_0001, 5'd13);
    op4(2'b01, 32'hFFFF_FFFF, 5'd31);
    op4(2'b00, 32'h1234_5678, 5'd0);
    op4(2'b01, 32'h0F0F_0F0F, 5'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
